// File: rtl/booth_op_scheduler.sv
// Operand scheduler around a 4x4 signed Booth multiplier: buffers operand pairs,
// issues them one at a time with a start pulse, and presents each product downstream.
module booth_op_scheduler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  output logic       mul_str,
  input  logic [7:0] mul_result,
  input  logic       mul_valid,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_product,
  output logic [3:0] out_a,
  output logic [3:0] out_b,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state_q;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] wr_ptr_d, rd_ptr_d;
  logic [7:0]  fifo_mem [DEPTH];
  logic [7:0]  wait_cnt_q;
  logic [3:0]  mul_a_q, mul_b_q;
  logic        mul_str_q;
  logic        out_valid_q;
  logic [7:0]  out_product_q;
  logic [3:0]  out_a_q, out_b_q;
  logic        timeout_err_q;

  logic fifo_empty, fifo_full, push, pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready   = ~fifo_full;
  assign push       = in_valid & ~fifo_full;
  assign pop        = (state_q == S_IDLE) & ~fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  // Storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= {in_a, in_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      wait_cnt_q    <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_str_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            mul_a_q   <= fifo_mem[rd_ptr_q[AW-1:0]][7:4];
            mul_b_q   <= fifo_mem[rd_ptr_q[AW-1:0]][3:0];
            mul_str_q <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mul_str_q <= 1'b0;
          state_q   <= S_GUARD;
        end
        // mul_valid may still be high from the previous operation here.
        S_GUARD: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_valid) begin
            out_product_q <= mul_result;
            out_a_q       <= mul_a_q;
            out_b_q       <= mul_b_q;
            out_valid_q   <= 1'b1;
            state_q       <= S_HOLD;
          end else if (wait_cnt_q == TMO) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign mul_str     = mul_str_q;
  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: doc/booth_op_scheduler.md
# booth_op_scheduler

Operand scheduler and result collector wrapped around the 4x4 signed Booth multiplier. Accepts operand pairs through a valid/ready input port and buffers them in a small FIFO. Issues each pair to the multiplier with a one-cycle start pulse, waits for the multiplier's done flag and captures the 8-bit product. Presents the product, together with its operands, on a valid/ready output port; a bounded wait raises a sticky error if the multiplier never completes.

## Interface
- DEPTH, 4, operand FIFO entries; power of two, 2..16
- TIMEOUT, 15, max WAIT cycles before abort; 1..255
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream offers an operand pair
- in_ready  out  1  FIFO not full; pair accepted when in_valid & in_ready
- in_a  in  4  multiplicand, two's complement
- in_b  in  4  multiplier, two's complement
- mul_a  out  4  multiplicand to multiplier, held stable from ISSUE until leaving WAIT
- mul_b  out  4  multiplier operand, same hold rule
- mul_str  out  1  start pulse, exactly one cycle per operation
- mul_result  in  8  product from multiplier
- mul_valid  in  1  multiplier done flag; level-sampled
- out_valid  out  1  product available
- out_ready  in  1  downstream accepts; transfer when out_valid & out_ready
- out_product  out  8  captured signed product
- out_a, out_b  out  4 each  operands that produced out_product
- busy  out  1  state != IDLE or FIFO non-empty
- timeout_err  out  1  sticky; set on any aborted operation

## Operation
- FIFO: DEPTH entries of {a,b}; write/read pointers of log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full = MSBs differ and low bits equal; empty = pointers equal.
- Push and pop in the same cycle are both honoured. When full, a simultaneous pop frees a slot, but in_ready stays low that cycle; it is registered-free combinational from the current count only.
- FSM states: IDLE, ISSUE, GUARD, WAIT, HOLD.
- IDLE: if FIFO non-empty, pop the head into the op registers (mul_a/mul_b) and go to ISSUE; otherwise stay.
- ISSUE: mul_str=1 for this cycle only; go to GUARD.
- GUARD: mul_valid ignored, because a stale done flag from the previous operation may still be high. Clear wait counter; go to WAIT.
- WAIT, mul_valid=1: capture mul_result into out_product and mul_a/mul_b into out_a/out_b; go to HOLD.
- WAIT, mul_valid=0: increment wait counter. When the counter equals TIMEOUT, set timeout_err, discard the operation, and go to IDLE without asserting out_valid.
- HOLD: out_valid=1 with out_* stable; on out_ready go to IDLE; otherwise stay. No new issue while in HOLD.
- Product is passed through unmodified (8-bit two's complement); no saturation or sign handling in this block.
- timeout_err clears only on reset.

## Timing
- Reset values: in_ready=1, mul_str=0, mul_a=mul_b=0, out_valid=0, out_product=0, out_a=out_b=0, busy=0, timeout_err=0; FSM=IDLE, pointers=0, wait counter=0.
- Reset mid-operation takes effect asynchronously: the FIFO is emptied, the in-flight operation is dropped, and mul_str drops immediately.
- Push at edge T into an empty FIFO: pop at edge T+1 (IDLE->ISSUE); mul_str high during cycle T+1..T+2; WAIT entered at edge T+3.
- Multiplier done seen in WAIT at edge W: out_valid high from W, i.e. the cycle after that edge.
- Back-to-back throughput: with out_ready held high and the FIFO non-empty, consecutive mul_str pulses are separated by the multiplier latency plus 4 cycles (HOLD, IDLE, ISSUE, GUARD).
- Timeout: abort edge occurs TIMEOUT+1 edges after entering WAIT; timeout_err is high from the next cycle.
- in_ready falls the cycle after the DEPTH-th unpopped push.

## Test plan
- Single op: push a=3, b=-2 (0x3, 0xE); model returns 0xFA -> exactly one mul_str pulse; out_valid with out_product=0xFA, out_a=3, out_b=0xE.
- Corner products: (-8,-8)->0x40, (7,-8)->0xC8, (0,5)->0x00 -> each forwarded in push order with matching operands.
- FIFO full: hold out_ready=0, push 6 pairs -> exactly 5 accepted (1 in flight, 4 buffered); in_ready low after the 5th. Release out_ready -> all 5 delivered in order, then in_ready=1.
- Stale done: multiplier model holds mul_valid high through the next ISSUE/GUARD -> no capture in GUARD; second product captured only from WAIT.
- Timeout: model never asserts mul_valid -> timeout_err=1 after TIMEOUT+1 WAIT edges, no out_valid, and the next queued pair is still issued and completes.
- Async reset asserted in WAIT with 2 pairs queued -> all outputs go to reset values immediately; after release, no mul_str until a new push.
